// File: rtl/imem_sync_pp.sv
// Synchronous-read instruction memory for the IF stage with a guarded runtime programming port.
module imem_sync_pp #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        PC_W      = 32,
    parameter int unsigned        DEPTH     = 64,
    parameter int unsigned        BYTE_ADDR = 0,
    parameter logic [DATA_W-1:0]  NOP_WORD  = '0,
    parameter int unsigned        IDX_W     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_W-1:0]     PC_In,
    input  logic                fetch_en,
    input  logic                flush,
    output logic [DATA_W-1:0]   Instr,
    output logic                instr_valid,
    output logic                addr_err,
    input  logic                prog_en,
    input  logic                prog_we,
    input  logic [IDX_W:0]      prog_addr,
    input  logic [DATA_W-1:0]   prog_data,
    output logic                prog_busy,
    output logic [IDX_W:0]      prog_count
);

    localparam int unsigned         CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]     DEPTH_PC  = PC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PROG  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PC_W-1:0]   word_c;
    logic [IDX_W-1:0]  idx_c;
    logic              misalign_c;
    logic              fetch_bad_c;
    logic              wr_req_c;
    logic              wr_ok_c;
    logic              wr_bad_c;

    logic [DATA_W-1:0] instr_nxt;
    logic              valid_nxt;
    logic              err_nxt;
    logic              busy_nxt;
    logic [CNT_W-1:0]  count_nxt;

    // Word index from PC; upper bits are kept so out-of-range PCs are caught, not aliased
    always_comb begin
        word_c = PC_In;
        if (BYTE_ADDR != 0) begin
            word_c = PC_In >> 2;
        end
    end

    assign idx_c       = word_c[IDX_W-1:0];
    assign misalign_c  = (BYTE_ADDR != 0) && (PC_In[1:0] != 2'b00);
    assign fetch_bad_c = (word_c >= DEPTH_PC) || misalign_c;

    assign wr_req_c = prog_en && prog_we;
    assign wr_ok_c  = wr_req_c && (prog_addr < DEPTH_CNT);
    assign wr_bad_c = wr_req_c && !wr_ok_c;

    // Programming-mode sequencing: RUN -> PROG while prog_en held -> one DRAIN cycle -> RUN
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (prog_en) state_nxt = ST_PROG;
            ST_PROG:  if (!prog_en) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = prog_en ? ST_PROG : ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Next values of the fetch outputs and the programming counter
    always_comb begin
        instr_nxt = Instr;
        valid_nxt = instr_valid;
        err_nxt   = wr_bad_c;
        count_nxt = prog_count;
        busy_nxt  = (state_nxt != ST_RUN);

        // Entry into PROG restarts the count; a write on that same edge then counts as the first
        if ((state == ST_RUN) && prog_en) begin
            count_nxt = '0;
        end
        if (wr_ok_c && (count_nxt < DEPTH_CNT)) begin
            count_nxt = count_nxt + CNT_W'(1);
        end

        // Fetch is squashed whenever programming is active or requested, so no read/write overlap
        if ((state != ST_RUN) || prog_en || flush) begin
            instr_nxt = NOP_WORD;
            valid_nxt = 1'b0;
        end else if (fetch_en) begin
            if (fetch_bad_c) begin
                instr_nxt = NOP_WORD;
                valid_nxt = 1'b0;
                err_nxt   = 1'b1;
            end else begin
                instr_nxt = mem[idx_c];
                valid_nxt = 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            Instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            prog_busy   <= 1'b0;
            prog_count  <= '0;
        end else begin
            state       <= state_nxt;
            Instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            addr_err    <= err_nxt;
            prog_busy   <= busy_nxt;
            prog_count  <= count_nxt;
        end
    end

    // Instruction storage; contents survive reset, but a write on a reset edge is discarded
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_c) begin
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

endmodule

// File: tb/tb_imem_sync_pp.sv
// Directed bench for imem_sync_pp: word-indexed instance (DEPTH 64) plus byte-addressed instance (DEPTH 40).
module tb_imem_sync_pp;

    localparam logic [31:0] W0  = 32'h0022_1020;
    localparam logic [31:0] W1  = 32'h0064_2022;
    localparam logic [31:0] W2  = 32'h2022_0006;
    localparam logic [31:0] W3  = 32'h8CF4_0002;
    localparam logic [31:0] W9  = 32'hDEAD_0009;
    localparam logic [31:0] W63 = 32'hBEEF_003F;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_b;
    logic        fetch_en;
    logic        flush;
    logic        prog_en;
    logic        prog_we;
    logic [6:0]  prog_addr;
    logic [31:0] prog_data;

    logic [31:0] instr;
    logic        valid;
    logic        err;
    logic        busy;
    logic [6:0]  count;
    logic [31:0] instr_b;
    logic        valid_b;
    logic        err_b;
    logic        busy_b;
    logic [6:0]  count_b;

    int total;
    int bad;

    typedef struct packed {
        logic [31:0] pc;
        logic        fe;
        logic        fl;
        logic [31:0] ei;
        logic        ev;
        logic        ee;
    } vec_t;

    vec_t vecs [18];

    imem_sync_pp #(.DATA_W(32), .PC_W(32), .DEPTH(64), .BYTE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .PC_In(pc), .fetch_en(fetch_en), .flush(flush),
        .Instr(instr), .instr_valid(valid), .addr_err(err),
        .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_busy(busy), .prog_count(count)
    );

    imem_sync_pp #(.DATA_W(32), .PC_W(32), .DEPTH(40), .BYTE_ADDR(1)) dut_b (
        .clk(clk), .rst(rst), .PC_In(pc_b), .fetch_en(fetch_en), .flush(flush),
        .Instr(instr_b), .instr_valid(valid_b), .addr_err(err_b),
        .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_busy(busy_b), .prog_count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        prog_en   = 1'b1;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
    endtask

    task automatic fetch_b(input logic [31:0] p, input logic [31:0] ei, input logic ev, input logic ee,
                           input string name);
        pc_b     = p;
        fetch_en = 1'b1;
        flush    = 1'b0;
        tick();
        chk({name, "_instr"}, instr_b, ei);
        chk({name, "_valid"}, 32'(valid_b), 32'(ev));
        chk({name, "_err"}, 32'(err_b), 32'(ee));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; pc = '0; pc_b = '0; fetch_en = 1'b0; flush = 1'b0;
        prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

        vecs[0]  = '{32'd0,  1'b1, 1'b0, W0,  1'b1, 1'b0};
        vecs[1]  = '{32'd1,  1'b1, 1'b0, W1,  1'b1, 1'b0};
        vecs[2]  = '{32'd2,  1'b1, 1'b0, W2,  1'b1, 1'b0};
        vecs[3]  = '{32'd3,  1'b1, 1'b0, W3,  1'b1, 1'b0};
        vecs[4]  = '{32'd2,  1'b1, 1'b0, W2,  1'b1, 1'b0};
        vecs[5]  = '{32'd9,  1'b0, 1'b0, W2,  1'b1, 1'b0};
        vecs[6]  = '{32'd9,  1'b0, 1'b0, W2,  1'b1, 1'b0};
        vecs[7]  = '{32'd9,  1'b0, 1'b0, W2,  1'b1, 1'b0};
        vecs[8]  = '{32'd9,  1'b1, 1'b0, W9,  1'b1, 1'b0};
        vecs[9]  = '{32'd1,  1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{32'd3,  1'b1, 1'b0, W3,  1'b1, 1'b0};
        vecs[11] = '{32'd64, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{32'd3,  1'b1, 1'b0, W3,  1'b1, 1'b0};
        vecs[13] = '{32'h8000_0001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[14] = '{32'd64, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[15] = '{32'd0,  1'b0, 1'b1, 32'h0, 1'b0, 1'b0};
        vecs[16] = '{32'd63, 1'b1, 1'b0, W63, 1'b1, 1'b0};
        vecs[17] = '{32'd0,  1'b1, 1'b0, W0,  1'b1, 1'b0};

        // Reset values
        tick();
        tick();
        rst = 1'b0;
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_count", 32'(count), 32'h0);

        // Session 1: load mem[0..3]; busy is high for the 4 PROG cycles plus DRAIN
        wr(7'd0, W0);
        chk("s1_busy0", 32'(busy), 32'h1);
        chk("s1_count0", 32'(count), 32'h1);
        wr(7'd1, W1);
        wr(7'd2, W2);
        wr(7'd3, W3);
        chk("s1_busy3", 32'(busy), 32'h1);
        chk("s1_count", 32'(count), 32'h4);
        prog_en = 1'b0; prog_we = 1'b0;
        tick();
        chk("s1_drain_busy", 32'(busy), 32'h1);
        chk("s1_drain_valid", 32'(valid), 32'h0);
        tick();
        chk("s1_run_busy", 32'(busy), 32'h0);
        chk("s1_count_kept", 32'(count), 32'h4);

        // Session 2: count restarts on entry; addr 63 is out of range for the 40-deep instance
        wr(7'd9, W9);
        chk("s2_count_clr", 32'(count), 32'h1);
        wr(7'd63, W63);
        chk("s2_count", 32'(count), 32'h2);
        chk("s2_err", 32'(err), 32'h0);
        chk("s2b_err", 32'(err_b), 32'h1);
        chk("s2b_count", 32'(count_b), 32'h1);
        prog_en = 1'b0; prog_we = 1'b0;
        tick();
        chk("s2b_err_pulse", 32'(err_b), 32'h0);
        tick();

        // Fetch table: sequential fetch, stall-hold, flush, range errors
        for (int i = 0; i < 18; i++) begin
            pc       = vecs[i].pc;
            fetch_en = vecs[i].fe;
            flush    = vecs[i].fl;
            tick();
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].ei);
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].ee));
        end

        // Byte addressing on the 40-deep instance
        pc = '0;
        fetch_b(32'h8,   W2,    1'b1, 1'b0, "b_pc8");
        fetch_b(32'h6,   32'h0, 1'b0, 1'b1, "b_pc6");
        fetch_b(32'd36,  W9,    1'b1, 1'b0, "b_pc36");
        fetch_b(32'd160, 32'h0, 1'b0, 1'b1, "b_pc160");
        fetch_b(32'hC,   W3,    1'b1, 1'b0, "b_pc12");

        // Bad write on entry, then saturation of the count at DEPTH
        wr(7'd70, 32'h5555_5555);
        chk("s5_err", 32'(err), 32'h1);
        chk("s5_count", 32'(count), 32'h0);
        chk("s5_valid", 32'(valid), 32'h0);
        for (int k = 0; k < 70; k++) begin
            wr(7'(k % 64), 32'hA000_0000 + 32'(k));
            if (k == 0) begin
                chk("s5_err_pulse", 32'(err), 32'h0);
                chk("s5_count1", 32'(count), 32'h1);
            end
            if (k == 63) chk("s5_count64", 32'(count), 32'd64);
        end
        chk("s5_count_sat", 32'(count), 32'd64);
        prog_en = 1'b0; prog_we = 1'b0;
        tick();
        chk("s5_drain_busy", 32'(busy), 32'h1);
        prog_en = 1'b1;
        tick();
        chk("s5_reenter_busy", 32'(busy), 32'h1);
        chk("s5_reenter_count", 32'(count), 32'd64);
        prog_en = 1'b0;
        tick();
        tick();
        chk("s5_run_busy", 32'(busy), 32'h0);

        // Reset in the middle of programming
        wr(7'd5, 32'h1111_1111);
        wr(7'd6, 32'h2222_2222);
        chk("s6_count", 32'(count), 32'h2);
        rst = 1'b1;
        wr(7'd7, 32'h3333_3333);
        rst = 1'b0; prog_en = 1'b0; prog_we = 1'b0;
        chk("s6_busy", 32'(busy), 32'h0);
        chk("s6_count", 32'(count), 32'h0);
        chk("s6_instr", instr, 32'h0);
        chk("s6_valid", 32'(valid), 32'h0);
        chk("s6_err", 32'(err), 32'h0);
        fetch_en = 1'b1; flush = 1'b0;
        pc = 32'd5;
        tick();
        chk("s6_mem5", instr, 32'h1111_1111);
        chk("s6_mem5_valid", 32'(valid), 32'h1);
        pc = 32'd6;
        tick();
        chk("s6_mem6", instr, 32'h2222_2222);
        pc = 32'd7;
        tick();
        chk("s6_mem7", instr, 32'hA000_0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
